// File: rtl/aes256_iter_ctrl.sv
// Iterative AES-256 encryption controller: one cipher round plus one key-expansion
// step per clock, with valid/ready handshakes on the plaintext and ciphertext sides.
module aes256_iter_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key,
  input  logic [127:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [255:0] kreg_q, kreg_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] sr_w, mc_w, rk_w, round_w;
  logic [255:0] kexp_w;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 = x^2*x^4*...*x^128, followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;
    p2   = gf_mul(x, x);
    p4   = gf_mul(p2, p2);
    p8   = gf_mul(p4, p4);
    p16  = gf_mul(p8, p8);
    p32  = gf_mul(p16, p16);
    p64  = gf_mul(p32, p32);
    p128 = gf_mul(p64, p64);
    inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                  gf_mul(gf_mul(p32, p64), p128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One 256-bit expansion step: produces the next eight schedule words from the last eight.
  function automatic logic [255:0] key_expand(input logic [255:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    n0 = k[255:224] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n1 = k[223:192] ^ n0;
    n2 = k[191:160] ^ n1;
    n3 = k[159:128] ^ n2;
    n4 = k[127:96]  ^ sub_word(n3);
    n5 = k[95:64]   ^ n4;
    n6 = k[63:32]   ^ n5;
    n7 = k[31:0]    ^ n6;
    return {n0, n1, n2, n3, n4, n5, n6, n7};
  endfunction

  // Odd rounds use the lower half of kreg, even rounds the upper half of the expanded value.
  always_comb begin
    sr_w    = shift_rows(sub_bytes(st_q));
    mc_w    = mix_columns(sr_w);
    rk_w    = rnd_q[0] ? kreg_q[127:0] : kreg_q[255:128];
    round_w = ((rnd_q == 4'd14) ? sr_w : mc_w) ^ rk_w;
    kexp_w  = key_expand(kreg_q, rcon_q);
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    kreg_d      = kreg_q;
    rnd_d       = rnd_q;
    rcon_d      = rcon_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in ^ key[255:128];
          kreg_d  = key;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d  = round_w;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q[0]) begin
          kreg_d = kexp_w;
          rcon_d = {rcon_q[6:0], 1'b0};
        end
        if (rnd_q == 4'd14) begin
          out_d       = round_w;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      kreg_q      <= '0;
      rnd_q       <= '0;
      rcon_q      <= 8'h01;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      kreg_q      <= kreg_d;
      rnd_q       <= rnd_d;
      rcon_q      <= rcon_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes256_iter_ctrl.sv
// Self-checking bench for aes256_iter_ctrl: known-answer vectors, handshake corner
// cases, and randomized traffic scored against a behavioural AES-256 model.
module tb_aes256_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key;
  logic [127:0] din;
  logic         in_valid, in_ready;
  logic [127:0] dout;
  logic         out_valid, out_ready, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  aes256_iter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .in        (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural AES-256 model ----------------
  logic [7:0] sbox_tb [256];

  // S-box from the generator-3 log/antilog walk: p runs over x*3^k, q over 3^-k.
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tb[p] = x ^ 8'h63;
    end
    sbox_tb[0] = 8'h63;
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes256_ref(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = mul2(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 14; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_tb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 14) begin
          s[0][c] = mul2(t[0][c]) ^ mul2(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ mul2(t[1][c]) ^ mul2(t[2][c]) ^ t[2][c] ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ mul2(t[2][c]) ^ mul2(t[3][c]) ^ t[3][c];
          s[3][c] = mul2(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ mul2(t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- handshake monitor / scoreboard ----------------
  logic [127:0] exp_q [$];
  logic [127:0] out_hist [$];
  int           acc_hist [$];
  int           acc_cyc = 0;
  int           n_acc = 0;
  int           n_out = 0;
  bit           mon_en = 1'b0;
  logic         prev_ov = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(aes256_ref(key, din));
        acc_cyc = cyc + 1;
        acc_hist.push_back(acc_cyc);
        n_acc++;
      end
      if (out_valid && !prev_ov) chk("mon_latency", cyc - acc_cyc, 14);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("mon_unexpected_output", 1'b1, 1'b0);
        else                   chk("mon_ciphertext", dout, exp_q.pop_front());
        out_hist.push_back(dout);
        n_out++;
      end
      chk("mon_out_valid_outside_done", out_valid && (busy || in_ready), 1'b0);
    end
    prev_ov = out_valid;
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t         vecs [4];
  int           lat;
  logic [127:0] res;

  // Entered at posedge+1 with the DUT idle; returns at the first negedge showing out_valid.
  task automatic run_block(input logic [255:0] k, input logic [127:0] p,
                           output int l, output logic [127:0] r);
    key = k; din = p; in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; key = rand256(); din = rand128();
    @(negedge clk);
    chk("busy_after_accept", busy, 1'b1);
    chk("in_ready_after_accept", in_ready, 1'b0);
    l = 0;
    r = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        l = i;
        r = dout;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    rst = 1'b0; key = '0; din = '0; in_valid = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset_out", dout, '0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    vecs[0].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    vecs[0].pt  = 128'h00112233445566778899aabbccddeeff;
    vecs[0].ct  = 128'h8ea2b7ca516745bfeafc49904b496089;
    vecs[1].key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    vecs[1].pt  = 128'h6bc1bee22e409f96e93d7e117393172a;
    vecs[1].ct  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    vecs[2].key = rand256();
    vecs[2].pt  = rand128();
    vecs[2].ct  = aes256_ref(vecs[2].key, vecs[2].pt);
    vecs[3].key = '1;
    vecs[3].pt  = '0;
    vecs[3].ct  = aes256_ref(vecs[3].key, vecs[3].pt);

    // Known-answer table, out_ready tied high.
    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].key, vecs[v].pt, lat, res);
      chk($sformatf("vec%0d_latency", v), lat, 14);
      chk($sformatf("vec%0d_ciphertext", v), res, vecs[v].ct);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid_one_cycle", v), out_valid, 1'b0);
      chk($sformatf("vec%0d_in_ready_after_out", v), in_ready, 1'b1);
      chk($sformatf("vec%0d_out_held", v), dout, vecs[v].ct);
      @(posedge clk); #1;
    end

    // Backpressure with in_valid asserted during DONE.
    out_ready = 1'b0;
    run_block(vecs[0].key, vecs[0].pt, lat, res);
    chk("bp_latency", lat, 14);
    chk("bp_ciphertext", res, vecs[0].ct);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; key = rand256(); din = rand128();
      @(negedge clk);
      chk("bp_out_valid_held", out_valid, 1'b1);
      chk("bp_out_stable", dout, vecs[0].ct);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_valid_before_release", out_valid, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_valid_after_handshake", out_valid, 1'b0);
    chk("bp_in_ready_after_handshake", in_ready, 1'b1);
    chk("bp_input_not_consumed", busy, 1'b0);
    @(posedge clk); #1;

    // Back-to-back with in_valid held and inputs scrambled during RUN.
    exp_q.delete(); out_hist.delete(); acc_hist.delete();
    n_acc = 0; n_out = 0; mon_en = 1'b1;
    key = vecs[0].key; din = vecs[0].pt; in_valid = 1'b1;
    @(posedge clk); #1;
    repeat (15) begin
      key = rand256(); din = rand128();
      @(posedge clk); #1;
    end
    key = vecs[1].key; din = vecs[1].pt;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 60 && n_out < 2; i++) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("b2b_output_count", n_out, 2);
    chk("b2b_accept_count", n_acc, 2);
    if (acc_hist.size() == 2) chk("b2b_accept_spacing", acc_hist[1] - acc_hist[0], 16);
    else                      chk("b2b_accept_spacing", acc_hist.size(), 2);
    if (out_hist.size() == 2) begin
      chk("b2b_first_ct", out_hist[0], vecs[0].ct);
      chk("b2b_second_ct", out_hist[1], vecs[1].ct);
    end else begin
      chk("b2b_out_hist", out_hist.size(), 2);
    end
    @(posedge clk); #1;

    // Asynchronous reset while round 7 is executing.
    key = vecs[0].key; din = vecs[0].pt; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready_before", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_out", dout, '0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    run_block(vecs[1].key, vecs[1].pt, lat, res);
    chk("rst_post_latency", lat, 14);
    chk("rst_post_ciphertext", res, vecs[1].ct);
    @(posedge clk); #1;

    // Randomized traffic with stalls on both sides.
    exp_q.delete(); out_hist.delete(); acc_hist.delete();
    n_acc = 0; n_out = 0; mon_en = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      int guard;
      bit acc;
      guard = 0;
      acc   = 1'b0;
      key = rand256(); din = rand128();
      while (!acc && guard < 200) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      if (!acc) chk("rand_accept_timeout", guard, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 60 && n_out < n_acc; i++) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    chk("rand_accept_count", n_acc, 1000);
    chk("rand_output_count", n_out, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
